// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: core data bus plus SRAM port of the data-memory controller.
// master = core/SRAM side, slave = controller.
interface dmem_ctrl_if #(parameter int ADDR_W = 14);
    logic [31:0]       DAD;
    logic [31:0]       ddt_in;
    logic [31:0]       ddt_out;
    logic              MREQ;
    logic              WRITE;
    logic [1:0]        SIZE;
    logic              ACKD_n;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              misalign_err;
    modport master (
        output DAD, ddt_in, MREQ, WRITE, SIZE, mem_rdata,
        input  ddt_out, ACKD_n, mem_en, mem_we, mem_be, mem_addr, mem_wdata, misalign_err
    );
    modport slave (
        input  DAD, ddt_in, MREQ, WRITE, SIZE, mem_rdata,
        output ddt_out, ACKD_n, mem_en, mem_we, mem_be, mem_addr, mem_wdata, misalign_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller with wait states, lane steering and misalignment flagging.
// Optional access/wait/error counters enabled by defining DMEM_CTRL_STATS_EN.
module dmem_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_ctrl_if.slave  bus
`ifdef DMEM_CTRL_STATS_EN
    ,
    output logic [31:0] stat_access,
    output logic [31:0] stat_wait,
    output logic [15:0] stat_err
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RESP} state_t;
    state_t            st;
    logic [3:0]        cnt;
    logic [1:0]        a_q, sz_q;
    logic              wr_q, mis_q;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata, hold;
    logic [1:0]        a, sz;
    logic              wr, mis, go_issue;
    logic [3:0]        be;
    logic [31:0]       rd;

    // In IDLE the live request is decoded so a zero-wait access can issue next cycle
    always_comb begin
        a        = (st == IDLE) ? bus.DAD[1:0] : a_q;
        sz       = (st == IDLE) ? bus.SIZE : sz_q;
        wr       = (st == IDLE) ? bus.WRITE : wr_q;
        mis      = (sz == 2'b11) || (sz == 2'b10 && a != 2'b00) || (sz == 2'b01 && a[0]);
        be       = (sz == 2'b00) ? 4'b0001 << a : (sz == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        go_issue = (st == IDLE && bus.MREQ && WAIT_CYCLES == 0) || (st == WAIT && cnt == 4'd1);
        rd       = mis_q ? 32'h0 :
                   (sz_q == 2'b00) ? {24'h0, 8'(bus.mem_rdata >> {a_q, 3'b000})} :
                   (sz_q == 2'b01) ? {16'h0, a_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0]} :
                   bus.mem_rdata;
    end

    assign bus.ACKD_n    = (st == IDLE) ? bus.MREQ : (st != RESP);
    assign bus.ddt_out   = (st == RESP) ? rd : hold;
    assign bus.mem_addr  = waddr;
    assign bus.mem_wdata = wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st               <= IDLE;
            cnt              <= 4'd0;
            a_q              <= 2'd0;
            sz_q             <= 2'd0;
            wr_q             <= 1'b0;
            mis_q            <= 1'b0;
            waddr            <= '0;
            wdata            <= 32'h0;
            hold             <= 32'h0;
            bus.mem_en       <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_be       <= 4'h0;
            bus.misalign_err <= 1'b0;
        end else begin
            bus.mem_en       <= go_issue;
            bus.mem_we       <= go_issue && wr && !mis;
            bus.mem_be       <= (go_issue && !mis) ? be : 4'h0;
            bus.misalign_err <= (st == ISSUE) && mis_q;
            case (st)
                IDLE: if (bus.MREQ) begin
                    a_q   <= bus.DAD[1:0];
                    sz_q  <= bus.SIZE;
                    wr_q  <= bus.WRITE;
                    mis_q <= mis;
                    waddr <= bus.DAD[ADDR_W+1:2];
                    wdata <= (bus.SIZE == 2'b00) ? {4{bus.ddt_in[7:0]}} :
                             (bus.SIZE == 2'b01) ? {2{bus.ddt_in[15:0]}} : bus.ddt_in;
                    cnt   <= 4'(WAIT_CYCLES);
                    st    <= (WAIT_CYCLES == 0) ? ISSUE : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) st <= ISSUE;
                end
                ISSUE: st <= RESP;
                default: begin
                    hold <= rd;
                    st   <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_access <= 32'h0;
            stat_wait   <= 32'h0;
            stat_err    <= 16'h0;
        end else begin
            if (st == RESP) stat_access <= stat_access + 32'd1;
            if (bus.ACKD_n && (bus.MREQ || st != IDLE)) stat_wait <= stat_wait + 32'd1;
            if (bus.misalign_err) stat_err <= stat_err + 16'd1;
        end
    end
`endif
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the core's MEM stage.
- Terminates the core's data bus (DAD, DDT, MREQ, WRITE, SIZE) and generates ACKD_n with a configurable number of wait states.
- Drives a single-port synchronous SRAM (one-cycle read latency) with byte enables.
- Handles byte/half/word lane steering and flags misaligned accesses.

Parameters:
- WAIT_CYCLES, 1, extra wait cycles inserted before the SRAM access (0..15).
- ADDR_W, 14, SRAM word-address width (capacity 4*2^ADDR_W bytes).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- DAD  in  32  byte address from core
- ddt_in  in  32  store data from core, right-aligned (top-level DDT when WRITE=1)
- ddt_out  out  32  load data to core, right-aligned (top-level drives DDT when WRITE=0)
- MREQ  in  1  access request, 1=access
- WRITE  in  1  1=store, 0=load
- SIZE  in  2  00=byte, 01=half, 10=word, 11=reserved
- ACKD_n  out  1  0=ready/complete, 1=core must hold
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write enable
- mem_be  out  4  SRAM byte enables
- mem_addr  out  ADDR_W  SRAM word address = DAD[ADDR_W+1:2]
- mem_wdata  out  32  SRAM write data, lane-replicated
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en
- misalign_err  out  1  one-cycle pulse coincident with the ACK of a faulting access

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset state:
  - FSM in IDLE; address, size, write and data latches and the counter cleared.
  - Outputs at reset: ddt_out=0, mem_en=0, mem_we=0, mem_be=0, misalign_err=0.
  - ACKD_n follows the IDLE rule below.
- IDLE:
  - ACKD_n = MREQ (combinational), so a new request is stalled immediately.
  - On MREQ=1: latch DAD, SIZE, WRITE and ddt_in, and compute misalignment.
  - Next state is WAIT with cnt=WAIT_CYCLES, or ISSUE if WAIT_CYCLES=0.
- WAIT: ACKD_n=1; cnt decrements each cycle; at cnt==1, go to ISSUE.
- ISSUE:
  - ACKD_n=1 and mem_en=1.
  - mem_we=1 only for an aligned store; mem_be set per lane; next state RESP.
- RESP:
  - ACKD_n=0; ddt_out valid; misalign_err=1 if the access faulted.
  - Next state IDLE unconditionally.
  - The core's interlock releases on this edge, so a MREQ seen in the following IDLE cycle is a new access.
- Latency: request seen in cycle 0 is acknowledged in cycle WAIT_CYCLES+2. Back-to-back requests incur no extra bubble beyond the IDLE cycle.
- Lanes, keyed by latched a=DAD[1:0]:
  - byte: mem_be=1<<a; mem_wdata = ddt_in[7:0] replicated x4; ddt_out = {24'b0, byte lane a}.
  - half: mem_be = a[1] ? 1100 : 0011; mem_wdata = ddt_in[15:0] replicated x2; ddt_out = {16'b0, half lane a[1]}.
  - word: mem_be=1111; data passed through unchanged.
  - Sign extension is the core's job.
- Misaligned access (half with a[0]=1, word with a!=0, or SIZE=11):
  - The FSM still runs its full sequence.
  - No SRAM write occurs (mem_we=0, mem_be=0); ddt_out=0; misalign_err pulses in RESP.
- Request inputs are sampled only in IDLE. If MREQ drops mid-access (e.g. a flush), the latched access still completes.
- ddt_out holds its value outside RESP and is don't-care there. mem_* outputs are 0 outside ISSUE, except mem_addr and mem_wdata, which hold their latched values.
- Reset asserted mid-operation: the FSM returns to IDLE at once, and a pending store is discarded if ISSUE has not yet occurred.

Optional Feature:
- Macro: DMEM_CTRL_STATS_EN.
- When defined, adds outputs stat_access[31:0], stat_wait[31:0] and stat_err[15:0]:
  - stat_access increments once per RESP.
  - stat_wait increments on every cycle with ACKD_n=1 and MREQ=1 or FSM not IDLE.
  - stat_err increments once per misalign_err.
  - All three reset to 0 and wrap on overflow.
- When undefined, these ports and counters are absent.

Test Plan:
- Load word: WAIT_CYCLES=2, SRAM[0x10]=0xDEADBEEF; load word at DAD=0x40 in cycle 0 -> ACKD_n=1 in cycles 0-3, mem_en=1 in cycle 3, ACKD_n=0 with ddt_out=0xDEADBEEF in cycle 4.
- Store byte: store byte at DAD=0x43 with ddt_in=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1 in ISSUE; a following load word returns 0xA5ADBEEF.
- Load half: SRAM[0x10]=0xDEADBEEF; load half at 0x42 -> ddt_out=0x0000DEAD; load byte at 0x41 -> ddt_out=0x000000BE.
- Misaligned store: store word at 0x46 -> mem_we never 1, SRAM unchanged, misalign_err=1 in the ACK cycle, which is still at cycle WAIT_CYCLES+2.
- Back-to-back and zero wait: WAIT_CYCLES=0, MREQ held high for two loads -> ACKD_n low in cycles 2 and 5; rst_n pulsed low during WAIT of a store -> no SRAM write, ACKD_n=0 after reset with MREQ=0.
